// File: rtl/coord_addsub_pipe.sv
// coord_addsub_pipe
//   Two-stage pipelined modular add/subtract for snake-grid coordinates.
//   Operands and results live in 0..LIMIT-1. Results wrap modulo LIMIT.
//   Stage 1 registers the raw WIDTH+1 bit sum/difference, the borrow flag
//   and the operand range check. Stage 2 applies the modular correction and
//   drives the output registers. The whole pipe advances when the output
//   slot is empty or is being taken, so bubbles are squeezed out.
//
// Parameters
//   WIDTH  operand/result width in bits
//   LIMIT  grid dimension, 2 <= LIMIT <= 2**WIDTH
//
// Build option
//   COORD_ADDSUB_SAT_EN  when defined, an overflowing add clamps to LIMIT-1
//                        and an underflowing subtract clamps to 0. wrap then
//                        flags the clamp. Handshake and range_err unchanged.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operand transaction valid
//   in_ready   unit accepts a transaction this cycle
//   a, b       operands (a - b or a + b)
//   sub        1 = subtract, 0 = add
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   result     modular result
//   wrap       result crossed the grid edge (or was clamped)
//   range_err  an operand was >= LIMIT; result and wrap forced to 0
module coord_addsub_pipe #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wrap,
  output logic             range_err
);

  localparam logic [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);
`ifdef COORD_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);
`else
  // Low WIDTH bits of LIMIT. For LIMIT = 2**WIDTH this is zero, which makes
  // the correction a no-op and gives native wrap-around.
  localparam logic [WIDTH-1:0] LIM_LO = WIDTH'(LIMIT);
`endif

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH:0]   r_s1_raw;
  logic             r_s1_sub;
  logic             r_s1_borrow;
  logic             r_s1_rerr;

  // Output (stage 2) registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_wrap;
  logic             r_rerr;

  logic             w_advance;
  logic             w_in_fire;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_raw;
  logic             w_rerr;
  logic             w_borrow;
  logic [WIDTH-1:0] w_res;
  logic             w_wrap;
`ifndef COORD_ADDSUB_SAT_EN
  logic [WIDTH-1:0] w_sum_minus;
`endif

  // Handshake. in_ready is forced low while reset is asserted so nothing
  // is accepted into a pipe that is about to be cleared.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance && reset_n;
  assign w_in_fire = in_valid && in_ready;

  // Stage 1 combinational
  assign w_a_ext  = {1'b0, a};
  assign w_b_ext  = {1'b0, b};
  assign w_raw    = sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
  assign w_rerr   = (w_a_ext >= LIM) || (w_b_ext >= LIM);
  assign w_borrow = sub && (a < b);

`ifndef COORD_ADDSUB_SAT_EN
  // raw - LIMIT modulo 2**WIDTH only needs the low bits of both terms.
  assign w_sum_minus = r_s1_raw[WIDTH-1:0] - LIM_LO;
`endif

  // Stage 2 correction. Both operands are below LIMIT, so a single
  // add/subtract of LIMIT always lands back in range.
  always_comb begin
    w_res  = r_s1_raw[WIDTH-1:0];
    w_wrap = 1'b0;
    if (r_s1_rerr) begin
      w_res  = '0;
      w_wrap = 1'b0;
    end else if (r_s1_sub) begin
      if (r_s1_borrow) begin
        w_wrap = 1'b1;
`ifdef COORD_ADDSUB_SAT_EN
        w_res  = '0;
`else
        // Truncating raw+LIMIT to WIDTH bits undoes the two's-complement
        // borrow and yields the modular difference.
        w_res  = r_s1_raw[WIDTH-1:0] + LIM_LO;
`endif
      end
    end else if (r_s1_raw >= LIM) begin
      w_wrap = 1'b1;
`ifdef COORD_ADDSUB_SAT_EN
      w_res  = LIM_M1;
`else
      w_res  = w_sum_minus;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_raw    <= '0;
      r_s1_sub    <= 1'b0;
      r_s1_borrow <= 1'b0;
      r_s1_rerr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_wrap      <= 1'b0;
      r_rerr      <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid  <= w_in_fire;
      if (w_in_fire) begin
        r_s1_raw    <= w_raw;
        r_s1_sub    <= sub;
        r_s1_borrow <= w_borrow;
        r_s1_rerr   <= w_rerr;
      end
      r_out_valid <= r_s1_valid;
      // Output data only moves when a real transaction arrives; bubbles
      // leave the last result in place.
      if (r_s1_valid) begin
        r_result <= w_res;
        r_wrap   <= w_wrap;
        r_rerr   <= r_s1_rerr;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign wrap      = r_wrap;
  assign range_err = r_rerr;

endmodule

// File: tb/tb_coord_addsub_pipe.sv
module tb_coord_addsub_pipe;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_ready;

  logic         ir32, ov32, wr32, re32;
  logic [W-1:0] res32;
  logic         ir20, ov20, wr20, re20;
  logic [W-1:0] res20;

  always #5 clk = ~clk;

  coord_addsub_pipe #(.WIDTH(W), .LIMIT(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir32),
    .a(a), .b(b), .sub(sub), .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .wrap(wr32), .range_err(re32)
  );

  coord_addsub_pipe #(.WIDTH(W), .LIMIT(20)) u_dut20 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir20),
    .a(a), .b(b), .sub(sub), .out_valid(ov20), .out_ready(out_ready),
    .result(res20), .wrap(wr20), .range_err(re20)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: packed as result | wrap<<8 | range_err<<9
  function automatic int model(int av, int bv, bit s, int lim);
    int r;
    bit w;
    r = 0;
    w = 1'b0;
    if (av >= lim || bv >= lim) return (1 << 9);
    if (!s) begin
      r = av + bv;
      if (r >= lim) begin
        w = 1'b1;
`ifdef COORD_ADDSUB_SAT_EN
        r = lim - 1;
`else
        r = r - lim;
`endif
      end
    end else begin
      r = av - bv;
      if (r < 0) begin
        w = 1'b1;
`ifdef COORD_ADDSUB_SAT_EN
        r = 0;
`else
        r = r + lim;
`endif
      end
    end
    return r | (int'(w) << 8);
  endfunction

  function automatic int pack(logic [W-1:0] r, logic w, logic e);
    return int'(r) | (int'(w) << 8) | (int'(e) << 9);
  endfunction

  // Hand-computed expectations that differ between builds
`ifdef COORD_ADDSUB_SAT_EN
  localparam int E32_2M5  = 256;
  localparam int E20_2M5  = 256;
  localparam int E20_15P9 = 19 | 256;
  localparam int E20_19P1 = 19 | 256;
  localparam int E32_0M1  = 256;
  localparam int E20_0M1  = 256;
  localparam int E32_31P1 = 31 | 256;
`else
  localparam int E32_2M5  = 29 | 256;
  localparam int E20_2M5  = 17 | 256;
  localparam int E20_15P9 = 4 | 256;
  localparam int E20_19P1 = 0 | 256;
  localparam int E32_0M1  = 31 | 256;
  localparam int E20_0M1  = 19 | 256;
  localparam int E32_31P1 = 0 | 256;
`endif

  typedef struct {
    int av;
    int bv;
    bit s;
    int acc;
    int st;
  } txn_t;

  txn_t q[$];
  int   cyc    = 0;
  int   stalls = 0;
  bit   shown  = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_p32, prev_p20;
  logic rst_q = 1'b1;

  always @(posedge clk) rst_q <= reset_n;

  // Compare process: scoreboard, latency, handshake and stall stability
  always @(negedge clk) begin
    txn_t e;
    bit   exp_ready;
    bit   stall;
    cyc++;
    if (!rst_q) begin
      chk("rst_out_valid", int'(ov32) + int'(ov20), 0);
      chk("rst_outputs", pack(res32, wr32, re32) | pack(res20, wr20, re20), 0);
    end
    if (!reset_n) begin
      chk("rst_in_ready", int'(ir32) + int'(ir20), 0);
      q.delete();
      shown      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      exp_ready = !ov32 || out_ready;
      chk("in_ready32", int'(ir32), int'(exp_ready));
      chk("in_ready20", int'(ir20), int'(exp_ready));
      chk("out_valid_match", int'(ov20), int'(ov32));
      if (ov32) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = q[0];
          chk("result32", pack(res32, wr32, re32), model(e.av, e.bv, e.s, 32));
          chk("result20", pack(res20, wr20, re20), model(e.av, e.bv, e.s, 20));
          if (!shown) begin
            chk("latency", cyc - e.acc, 2 + stalls - e.st);
            shown = 1'b1;
          end
        end
      end
      if (prev_stall) begin
        chk("stall_hold32", pack(res32, wr32, re32), prev_p32);
        chk("stall_hold20", pack(res20, wr20, re20), prev_p20);
      end
      stall = ov32 && !out_ready;
      if (stall) stalls++;
      prev_stall = stall;
      prev_p32   = pack(res32, wr32, re32);
      prev_p20   = pack(res20, wr20, re20);
      if (ov32 && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        shown = 1'b0;
      end
      if (in_valid && exp_ready) begin
        e.av  = int'(a);
        e.bv  = int'(b);
        e.s   = sub;
        e.acc = cyc;
        e.st  = stalls;
        q.push_back(e);
      end
    end
  end

  // Single isolated op with literal expectations at exactly T+2
  task automatic dir_op(string nm, int av, int bv, bit s, int e32, int e20);
    @(posedge clk); #1;
    out_ready = 1'b1;
    a = W'(av); b = W'(bv); sub = s; in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_ready"}, int'(ir32), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, int'(ov32), 1);
    chk({nm, "_32"}, pack(res32, wr32, re32), e32);
    chk({nm, "_20"}, pack(res20, wr20, re20), e20);
  endtask

  // Caller is at posedge+1; returns at posedge+1 right after the transfer
  // with in_valid still high so ops can go back-to-back.
  task automatic send(int av, int bv, bit s);
    bit acc;
    int k;
    a = W'(av); b = W'(bv); sub = s; in_valid = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 50) begin
      @(negedge clk);
      if (ir32) acc = 1'b1;
      k++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(string nm);
    int k;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((q.size() != 0 || ov32) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_drained"}, q.size(), 0);
  endtask

  initial begin
    bit got;
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;

    chk("model_7m3",   model(7, 3, 1'b1, 32), 4);
    chk("model_2m5",   model(2, 5, 1'b1, 32), E32_2M5);
    chk("model_15p9",  model(15, 9, 1'b0, 20), E20_15P9);
    chk("model_19p0",  model(19, 0, 1'b0, 20), 19);
    chk("model_25p1",  model(25, 1, 1'b0, 20), 512);
    chk("model_9m2",   model(9, 2, 1'b1, 32), 7);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", int'(ir32), 1);

    dir_op("sub_nowrap", 7, 3, 1'b1, 4, 4);
    dir_op("sub_wrap",   2, 5, 1'b1, E32_2M5, E20_2M5);
    dir_op("add_np2",    15, 9, 1'b0, 24, E20_15P9);
    dir_op("add_edge",   19, 0, 1'b0, 19, 19);
    dir_op("add_lim1",   19, 1, 1'b0, 20, E20_19P1);
    dir_op("sub_0m1",    0, 1, 1'b1, E32_0M1, E20_0M1);
    dir_op("sub_eq",     13, 13, 1'b1, 0, 0);
    dir_op("add_31p1",   31, 1, 1'b0, E32_31P1, 512);
    dir_op("range_err",  25, 1, 1'b0, 26, 512);
    dir_op("after_err",  3, 3, 1'b0, 6, 6);
    drain("directed");

    // Backpressure: three ops back-to-back, 3 stall cycles on first output
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(1, 1, 1'b0);
        send(3, 4, 1'b0);
        send(9, 2, 1'b1);
        in_valid = 1'b0;
      end
      begin
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          @(negedge clk);
          if (ov32) got = 1'b1;
        end
        chk("bp_first_valid", int'(got), 1);
        chk("bp_first_result", int'(res32), 2);
        chk("bp_in_ready_stalled", int'(ir32), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Reset with a full pipeline and in_valid held high
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4, 5, 1'b0);
    send(6, 1, 1'b1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", int'(ir32), 1);
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_result", int'(ov32), 0);
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = W'($urandom_range(0, 31));
      b         = W'($urandom_range(0, 31));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
